memory_stage: RTL and testbench
===============================

# memory_stage

Fourth pipeline stage (M) between Excute (E) and Writeback (W). Registers the EM bus and captures the data-SRAM read response one cycle after E issued the request. Aligns and sign/zero-extends load data, and holds that data in a one-entry buffer while W back-pressures. Drives the MW bus and the M→D forwarding bus, and takes part in the valid/allowin handshake and the exception flush.

## Interface
Parameters: none. Widths come from `Defines.vh`: `EM_BUS_Wid`, `MW_BUS_Wid`, `MD_for_BUS_Wid` (=120), `WpD_BUS_Wid`.
- clk  in  1  single clock; all state updates on its rising edge
- rstn  in  1  reset; synchronous, active-low
- W_allowin  in  1  W can accept an instruction this cycle
- M_allowin  out  1  M can accept from E this cycle
- EM_valid  in  1  E presents a valid instruction
- EM_BUS  in  EM_BUS_Wid  {PB_BUS, pc, rf_wdata, gr_we, dest, res_from_mem[3:0], vaddr, ex, ecode[7:0], esubcode, csr_addr[13:0], csr_we, csr_wmask, csr_wdata}
- MW_valid  out  1  M presents a valid instruction to W
- MW_BUS  out  MW_BUS_Wid  {PB_BUS, pc, rf_wdata, gr_we, dest, vaddr, ex, ecode, esubcode, csr_addr, csr_we, csr_wmask, csr_wdata}
- MD_for_BUS  out  120  {res_from_mem[3:0], dest[4:0], rf_wdata[31:0], csr_we, csr_addr[13:0], csr_wmask[31:0], csr_wdata[31:0]}
- ex_en  in  1  exception/ertn commit flush from W
- data_sram_rdata  in  32  read data; valid only in the cycle after the request, i.e. the first cycle the load sits in M

## Operation
- res_from_mem encoding: [3] word, [1] half, [0] byte, [2] unsigned modifier on [1]/[0]. All-zero means not a load.
- Handshake: M_ready_go=1.
  - M_allowin = !M_valid || W_allowin.
  - MW_valid = M_valid.
  - On an edge with M_allowin: M_valid <= EM_valid && !ex_flag && !ex_en, and the bus register loads EM_BUS when EM_valid.
- Flush: ex_en clears the bus register to 0 and M_valid to 0 on the same edge, overriding any load.
- ex_flag:
  - Set when M_valid && ex_M.
  - Cleared by ex_en.
  - Set has priority over clear on the same edge.
  - While set, newly accepted instructions enter invalid.
- Exception: ex_M = M_valid && ex field. ecode/esubcode pass through unchanged. gr_we on MW_BUS = gr_we && !ex_M.
- Load data: raw = buf_valid ? buf_data : data_sram_rdata.
  - Byte: select by vaddr[1:0].
  - Half: select by vaddr[1].
  - Extension by [2] (zero) or sign.
  - rf_wdata_M = load ? extended : bus rf_wdata.
- Hold buffer:
  - Captures data_sram_rdata when M_valid && load && !buf_valid && !W_allowin.
  - Clears on any edge where M_allowin is 1, or on ex_en.
  - Reset clears buf_valid and buf_data to 0.
- Forward: dest field = dest & {5{M_valid && gr_we && !ex_M}}; csr_we field = csr_we && M_valid.

## Timing
- Latency: one cycle E→M and one cycle M→W. Throughput is one instruction per cycle with no stall.
- Reset values: M_valid=0, bus register=0, ex_flag=0, buf_valid=0. Consequently MW_valid=0, MW_BUS=0, MD_for_BUS=0, and M_allowin=1.
- Load in M with W_allowin=0 for N cycles: data is captured at the end of the first cycle and the buffer is used for the remaining cycles. rf_wdata stays stable across all N+1 cycles.
- ex_en together with a stall: the flush wins, and the buffer and M_valid are cleared.
- ex_en together with EM_valid && M_allowin: the incoming instruction is dropped.
- Reset mid-stall: all state returns to reset values on the next edge.

## Configuration
- MEM_LOAD_FWD_EN defined:
  - MD_for_BUS.rf_wdata carries the extended load data.
  - The res_from_mem field is forced to 0, so D forwards without stalling.
- MEM_LOAD_FWD_EN undefined:
  - MD_for_BUS carries the bus rf_wdata (the address) and the real res_from_mem.
  - D must stall on a load-use hazard.
  - The load data path to MW_BUS is unchanged.

## Test plan
- ld.w, vaddr=0x1000, rdata=0x8899AABB, W_allowin=1 → MW rf_wdata=0x8899AABB one cycle after entry; MW_valid pulses for 1 cycle.
- ld.b (signed), vaddr=0x1003, rdata=0x80112233 → rf_wdata=0xFFFFFF80. Same with ld.bu → 0x00000080. ld.h, vaddr=0x1002 → 0xFFFF8011.
- ld.w, rdata=0x12345678 in cycle 1, then rdata=0xDEADBEEF while W_allowin=0 for 3 cycles → rf_wdata=0x12345678 in all cycles; M_allowin=0 until W_allowin=1.
- Instruction with ex=1, ecode=ALE → MW gr_we=0, forward dest=0, and ex_flag set; the next EM_valid instruction enters with M_valid=0 until ex_en; after ex_en, normal flow resumes.
- ex_en asserted while a load is stalled with buf_valid=1 → M_valid=0, buf_valid=0, and MW_BUS=0 on the next cycle.
- add.w, dest=5, rf_wdata=0x7 → MD_for_BUS dest=5, data=0x7. ld.w to r6 with the macro on → res field 0 and data = load value; with the macro off → res field 4'b1000 and data = address.

Source files
------------

// File: rtl/memory_stage.sv
// memory_stage: M pipeline stage between E and W. Registers the EM bus, aligns load data and
// holds it across W back-pressure. Build option: MEM_LOAD_FWD_EN forwards load data to D.

`ifndef PB_BUS_Wid
`define PB_BUS_Wid 32
`endif
`ifndef EM_BUS_Wid
`define EM_BUS_Wid 235
`endif
`ifndef MW_BUS_Wid
`define MW_BUS_Wid 231
`endif
`ifndef MD_for_BUS_Wid
`define MD_for_BUS_Wid 120
`endif

module memory_stage (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       W_allowin,
    output logic                       M_allowin,
    input  logic                       EM_valid,
    input  logic [`EM_BUS_Wid-1:0]     EM_BUS,
    output logic                       MW_valid,
    output logic [`MW_BUS_Wid-1:0]     MW_BUS,
    output logic [`MD_for_BUS_Wid-1:0] MD_for_BUS,
    input  logic                       ex_en,
    input  logic [31:0]                data_sram_rdata
);

    // Pipeline state
    logic                   m_valid_q;
    logic [`EM_BUS_Wid-1:0] em_bus_q;
    logic                   ex_flag_q;
    logic                   buf_valid_q;
    logic [31:0]            buf_data_q;

    // EM bus fields
    logic [`PB_BUS_Wid-1:0] pb_bus;
    logic [31:0]            pc;
    logic [31:0]            bus_rf_wdata;
    logic                   gr_we;
    logic [4:0]             dest;
    logic [3:0]             res_from_mem;
    logic [31:0]            vaddr;
    logic                   ex;
    logic [7:0]             ecode;
    logic [8:0]             esubcode;
    logic [13:0]            csr_addr;
    logic                   csr_we;
    logic [31:0]            csr_wmask;
    logic [31:0]            csr_wdata;

    assign {pb_bus, pc, bus_rf_wdata, gr_we, dest, res_from_mem, vaddr, ex, ecode, esubcode,
            csr_addr, csr_we, csr_wmask, csr_wdata} = em_bus_q;

    logic        ex_m;
    logic        is_load;
    logic [31:0] raw_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] rf_wdata_m;
    logic [31:0] fwd_wdata;
    logic [3:0]  fwd_res;

    // M never stalls on its own, so it can accept whenever W drains it.
    assign M_allowin = !m_valid_q || W_allowin;
    assign MW_valid  = m_valid_q;

    assign ex_m    = m_valid_q && ex;
    assign is_load = |res_from_mem;

    // SRAM data is only valid in the first M cycle; afterwards the held copy is used.
    always_comb begin
        raw_data = buf_valid_q ? buf_data_q : data_sram_rdata;

        byte_sel = raw_data[7:0];
        unique case (vaddr[1:0])
            2'b00: byte_sel = raw_data[7:0];
            2'b01: byte_sel = raw_data[15:8];
            2'b10: byte_sel = raw_data[23:16];
            2'b11: byte_sel = raw_data[31:24];
        endcase

        half_sel = vaddr[1] ? raw_data[31:16] : raw_data[15:0];

        load_data = raw_data;
        if (res_from_mem[3]) begin
            load_data = raw_data;
        end else if (res_from_mem[1]) begin
            load_data = {{16{half_sel[15] & ~res_from_mem[2]}}, half_sel};
        end else if (res_from_mem[0]) begin
            load_data = {{24{byte_sel[7] & ~res_from_mem[2]}}, byte_sel};
        end

        rf_wdata_m = is_load ? load_data : bus_rf_wdata;
    end

`ifdef MEM_LOAD_FWD_EN
    // Load value is final here, so D can bypass it without a load-use stall.
    assign fwd_wdata = rf_wdata_m;
    assign fwd_res   = 4'b0000;
`else
    assign fwd_wdata = bus_rf_wdata;
    assign fwd_res   = res_from_mem;
`endif

    assign MW_BUS = {pb_bus, pc, rf_wdata_m, gr_we && !ex_m, dest, vaddr, ex, ecode, esubcode,
                     csr_addr, csr_we, csr_wmask, csr_wdata};

    assign MD_for_BUS = {fwd_res,
                         dest & {5{m_valid_q && gr_we && !ex_m}},
                         fwd_wdata,
                         csr_we && m_valid_q,
                         csr_addr,
                         csr_wmask,
                         csr_wdata};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            m_valid_q   <= 1'b0;
            em_bus_q    <= '0;
            ex_flag_q   <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
        end else begin
            if (ex_en) begin
                m_valid_q <= 1'b0;
                em_bus_q  <= '0;
            end else if (M_allowin) begin
                m_valid_q <= EM_valid && !ex_flag_q;
                if (EM_valid) begin
                    em_bus_q <= EM_BUS;
                end
            end

            // Younger instructions stay invalid until the exception commits in W.
            if (ex_m) begin
                ex_flag_q <= 1'b1;
            end else if (ex_en) begin
                ex_flag_q <= 1'b0;
            end

            if (ex_en || M_allowin) begin
                buf_valid_q <= 1'b0;
                buf_data_q  <= '0;
            end else if (m_valid_q && is_load && !buf_valid_q && !W_allowin) begin
                buf_valid_q <= 1'b1;
                buf_data_q  <= data_sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage; expected MW_BUS words go through a scoreboard queue.

`ifndef PB_BUS_Wid
`define PB_BUS_Wid 32
`endif
`ifndef EM_BUS_Wid
`define EM_BUS_Wid 235
`endif
`ifndef MW_BUS_Wid
`define MW_BUS_Wid 231
`endif
`ifndef MD_for_BUS_Wid
`define MD_for_BUS_Wid 120
`endif

module tb_memory_stage;

    logic                       clk;
    logic                       rstn;
    logic                       W_allowin;
    logic                       M_allowin;
    logic                       EM_valid;
    logic [`EM_BUS_Wid-1:0]     EM_BUS;
    logic                       MW_valid;
    logic [`MW_BUS_Wid-1:0]     MW_BUS;
    logic [`MD_for_BUS_Wid-1:0] MD_for_BUS;
    logic                       ex_en;
    logic [31:0]                data_sram_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    logic [`MW_BUS_Wid-1:0] sb[$];

    localparam logic [31:0] PB    = 32'h0BAD_0001;
    localparam logic [13:0] CADDR = 14'h0004;
    localparam logic [31:0] CMASK = 32'hFFFF_FFFF;
    localparam logic [31:0] CDATA = 32'h1111_2222;

    memory_stage dut (
        .clk             (clk),
        .rstn            (rstn),
        .W_allowin       (W_allowin),
        .M_allowin       (M_allowin),
        .EM_valid        (EM_valid),
        .EM_BUS          (EM_BUS),
        .MW_valid        (MW_valid),
        .MW_BUS          (MW_BUS),
        .MD_for_BUS      (MD_for_BUS),
        .ex_en           (ex_en),
        .data_sram_rdata (data_sram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [`EM_BUS_Wid-1:0] mk_em(
        input logic [31:0] pc, input logic [31:0] rf, input logic gr_we, input logic [4:0] dest,
        input logic [3:0] res, input logic [31:0] vaddr, input logic ex, input logic [7:0] ecode);
        return {PB, pc, rf, gr_we, dest, res, vaddr, ex, ecode, 9'h000, CADDR, 1'b1, CMASK, CDATA};
    endfunction

    function automatic logic [`MW_BUS_Wid-1:0] mk_mw(
        input logic [31:0] pc, input logic [31:0] rf, input logic gr_we, input logic [4:0] dest,
        input logic [31:0] vaddr, input logic ex, input logic [7:0] ecode);
        return {PB, pc, rf, gr_we, dest, vaddr, ex, ecode, 9'h000, CADDR, 1'b1, CMASK, CDATA};
    endfunction

    function automatic logic [`MD_for_BUS_Wid-1:0] mk_md(
        input logic [3:0] res, input logic [4:0] dest, input logic [31:0] rf);
        return {res, dest, rf, 1'b1, CADDR, CMASK, CDATA};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Consume one MW transfer if W takes it, then advance to just after the next edge.
    task automatic run_cycle();
        logic [`MW_BUS_Wid-1:0] e;
        #1;
        if (MW_valid && W_allowin) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_output", {255'b0, MW_valid}, 256'd0);
            end else begin
                e = sb.pop_front();
                chk("mw_bus", MW_BUS, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_case(input string tag, input logic [3:0] res, input logic [31:0] vaddr,
                             input logic [31:0] rdata, input logic [31:0] exp_rf);
        logic [31:0] pc;
        pc = 32'h1C00_0000 + vaddr;
        EM_valid = 1'b1;
        EM_BUS   = mk_em(pc, vaddr, 1'b1, 5'd4, res, vaddr, 1'b0, 8'h00);
        sb.push_back(mk_mw(pc, exp_rf, 1'b1, 5'd4, vaddr, 1'b0, 8'h00));
        run_cycle();
        EM_valid        = 1'b0;
        data_sram_rdata = rdata;
        #1;
        chk({tag, "_mw_valid"}, MW_valid, 1);
        chk({tag, "_rf_wdata"}, MW_BUS[166:135], exp_rf);
        run_cycle();
        #1;
        chk({tag, "_mw_valid_pulse"}, MW_valid, 0);
        data_sram_rdata = 32'h0;
    endtask

    initial begin
        rstn            = 1'b0;
        W_allowin       = 1'b1;
        EM_valid        = 1'b0;
        EM_BUS          = '0;
        ex_en           = 1'b0;
        data_sram_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mw_valid", MW_valid, 0);
        chk("rst_mw_bus", MW_BUS, 0);
        chk("rst_md_bus", MD_for_BUS, 0);
        chk("rst_m_allowin", M_allowin, 1);
        rstn = 1'b1;
        run_cycle();

        // Load alignment and extension
        load_case("ldw", 4'b1000, 32'h0000_1000, 32'h8899_AABB, 32'h8899_AABB);
        load_case("ldb", 4'b0001, 32'h0000_1003, 32'h8011_2233, 32'hFFFF_FF80);
        load_case("ldbu", 4'b0101, 32'h0000_1003, 32'h8011_2233, 32'h0000_0080);
        load_case("ldh", 4'b0010, 32'h0000_1002, 32'h8011_2233, 32'hFFFF_8011);
        load_case("ldhu", 4'b0110, 32'h0000_1000, 32'h1234_F00D, 32'h0000_F00D);
        load_case("ldb1", 4'b0001, 32'h0000_1001, 32'h0000_7F00, 32'h0000_007F);

        // Load held across three cycles of W back-pressure
        EM_valid = 1'b1;
        EM_BUS   = mk_em(32'h1C00_0100, 32'h3000, 1'b1, 5'd9, 4'b1000, 32'h3000, 1'b0, 8'h00);
        sb.push_back(mk_mw(32'h1C00_0100, 32'h1234_5678, 1'b1, 5'd9, 32'h3000, 1'b0, 8'h00));
        run_cycle();
        EM_valid        = 1'b0;
        W_allowin       = 1'b0;
        data_sram_rdata = 32'h1234_5678;
        #1;
        chk("stall_rf_c0", MW_BUS[166:135], 32'h1234_5678);
        chk("stall_allowin_c0", M_allowin, 0);
        run_cycle();
        data_sram_rdata = 32'hDEAD_BEEF;
        for (int i = 1; i < 3; i++) begin
            #1;
            chk("stall_rf_held", MW_BUS[166:135], 32'h1234_5678);
            chk("stall_allowin", M_allowin, 0);
            run_cycle();
        end
        W_allowin = 1'b1;
        #1;
        chk("stall_rf_release", MW_BUS[166:135], 32'h1234_5678);
        chk("stall_allowin_release", M_allowin, 1);
        run_cycle();

        // Back-to-back ALU instructions, one per cycle
        EM_valid = 1'b1;
        EM_BUS   = mk_em(32'h1C00_0140, 32'hA1, 1'b1, 5'd10, 4'b0000, 32'h0, 1'b0, 8'h00);
        sb.push_back(mk_mw(32'h1C00_0140, 32'hA1, 1'b1, 5'd10, 32'h0, 1'b0, 8'h00));
        run_cycle();
        EM_BUS   = mk_em(32'h1C00_0144, 32'hA2, 1'b1, 5'd11, 4'b0000, 32'h0, 1'b0, 8'h00);
        sb.push_back(mk_mw(32'h1C00_0144, 32'hA2, 1'b1, 5'd11, 32'h0, 1'b0, 8'h00));
        run_cycle();
        EM_valid = 1'b0;
        #1;
        chk("b2b_second_valid", MW_valid, 1);
        run_cycle();

        // Exception in M: writeback and forwarding suppressed, younger instruction killed
        EM_valid = 1'b1;
        EM_BUS   = mk_em(32'h1C00_0200, 32'h55, 1'b1, 5'd7, 4'b0000, 32'h4001, 1'b1, 8'h09);
        sb.push_back(mk_mw(32'h1C00_0200, 32'h55, 1'b0, 5'd7, 32'h4001, 1'b1, 8'h09));
        run_cycle();
        EM_valid = 1'b0;
        #1;
        chk("ex_mw_valid", MW_valid, 1);
        chk("ex_gr_we", MW_BUS[134], 0);
        chk("ex_fwd_dest", MD_for_BUS[115:111], 0);
        run_cycle();
        EM_valid = 1'b1;
        EM_BUS   = mk_em(32'h1C00_0204, 32'h77, 1'b1, 5'd8, 4'b0000, 32'h0, 1'b0, 8'h00);
        run_cycle();
        EM_valid = 1'b0;
        #1;
        chk("exflag_entry_invalid", MW_valid, 0);
        chk("exflag_fwd_dest", MD_for_BUS[115:111], 0);
        chk("exflag_fwd_csr_we", MD_for_BUS[78], 0);
        ex_en = 1'b1;
        run_cycle();
        ex_en = 1'b0;
        #1;
        chk("exen_bus_cleared", MW_BUS, 0);

        // Normal flow resumes; forwarding of an ALU result
        EM_valid = 1'b1;
        EM_BUS   = mk_em(32'h1C00_0300, 32'h7, 1'b1, 5'd5, 4'b0000, 32'h0, 1'b0, 8'h00);
        sb.push_back(mk_mw(32'h1C00_0300, 32'h7, 1'b1, 5'd5, 32'h0, 1'b0, 8'h00));
        run_cycle();
        EM_valid = 1'b0;
        #1;
        chk("resume_valid", MW_valid, 1);
        chk("fwd_add", MD_for_BUS, mk_md(4'b0000, 5'd5, 32'h7));
        run_cycle();

        // ex_en drops an instruction arriving on the same edge
        EM_valid = 1'b1;
        ex_en    = 1'b1;
        EM_BUS   = mk_em(32'h1C00_0400, 32'h99, 1'b1, 5'd3, 4'b0000, 32'h0, 1'b0, 8'h00);
        run_cycle();
        EM_valid = 1'b0;
        ex_en    = 1'b0;
        #1;
        chk("exen_drop_incoming", MW_valid, 0);

        // Flush while a load is held in the buffer
        EM_valid = 1'b1;
        EM_BUS   = mk_em(32'h1C00_0500, 32'h5000, 1'b1, 5'd12, 4'b1000, 32'h5000, 1'b0, 8'h00);
        run_cycle();
        EM_valid        = 1'b0;
        W_allowin       = 1'b0;
        data_sram_rdata = 32'hCAFE_F00D;
        run_cycle();
        data_sram_rdata = 32'h0;
        #1;
        chk("buf_held", MW_BUS[166:135], 32'hCAFE_F00D);
        ex_en = 1'b1;
        run_cycle();
        ex_en     = 1'b0;
        W_allowin = 1'b1;
        #1;
        chk("flush_mw_valid", MW_valid, 0);
        chk("flush_mw_bus", MW_BUS, 0);
        chk("flush_allowin", M_allowin, 1);
        load_case("post_flush", 4'b1000, 32'h0000_5004, 32'h0BAD_BEEF, 32'h0BAD_BEEF);

        // Load forwarding to D
        EM_valid = 1'b1;
        EM_BUS   = mk_em(32'h1C00_0600, 32'h2000, 1'b1, 5'd6, 4'b1000, 32'h2000, 1'b0, 8'h00);
        sb.push_back(mk_mw(32'h1C00_0600, 32'h600D_F00D, 1'b1, 5'd6, 32'h2000, 1'b0, 8'h00));
        run_cycle();
        EM_valid        = 1'b0;
        data_sram_rdata = 32'h600D_F00D;
        #1;
        chk("fwd_ld_dest", MD_for_BUS[115:111], 6);
`ifdef MEM_LOAD_FWD_EN
        chk("fwd_ld_res", MD_for_BUS[119:116], 4'b0000);
        chk("fwd_ld_data", MD_for_BUS[110:79], 32'h600D_F00D);
`else
        chk("fwd_ld_res", MD_for_BUS[119:116], 4'b1000);
        chk("fwd_ld_data", MD_for_BUS[110:79], 32'h2000);
`endif
        run_cycle();
        data_sram_rdata = 32'h0;

        // Reset in the middle of a stall
        EM_valid = 1'b1;
        EM_BUS   = mk_em(32'h1C00_0700, 32'h7000, 1'b1, 5'd13, 4'b1000, 32'h7000, 1'b0, 8'h00);
        run_cycle();
        EM_valid        = 1'b0;
        W_allowin       = 1'b0;
        data_sram_rdata = 32'h1357_9BDF;
        run_cycle();
        rstn = 1'b0;
        run_cycle();
        rstn      = 1'b1;
        W_allowin = 1'b1;
        #1;
        chk("midrst_mw_valid", MW_valid, 0);
        chk("midrst_mw_bus", MW_BUS, 0);
        chk("midrst_md_bus", MD_for_BUS, 0);
        chk("midrst_allowin", M_allowin, 1);
        load_case("post_rst", 4'b1000, 32'h0000_7004, 32'h2468_ACE0, 32'h2468_ACE0);

        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
